gauss_stream_filter: RTL and testbench

GAUSS_STREAM_FILTER -- requirements
Module: gauss_stream_filter

---
 rtl/gauss_pkg.sv | 35 +++
 rtl/gauss_frame_mem.sv | 24 ++
 rtl/gauss_stream_filter.sv | 208 ++++++++++++++++++++
 tb/tb_gauss_stream_filter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gauss_pkg.sv
// Shared definitions for the streaming Gaussian filter: FSM encoding,
// border-handling modes and the elaboration-time helper functions.
package gauss_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_CONV = 3'd2,
    ST_EMIT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Border modes; code 3 falls through to replicate behaviour.
  localparam logic [1:0] BM_REPLICATE = 2'd0;
  localparam logic [1:0] BM_MIRROR    = 2'd1;
  localparam logic [1:0] BM_ZERO      = 2'd2;

  // Binomial coefficient C(n,k), evaluated on constants only.
  function automatic int binom(input int n, input int k);
    int r;
    r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  // Folds a possibly out-of-range tap coordinate back into [0, n-1].
  // In zero mode the returned index is a don't-care: the tap is masked.
  function automatic int map_coord(input int t, input int n, input logic [1:0] mode);
    if (t >= 0 && t < n) return t;
    if (mode == BM_MIRROR) return (t < 0) ? -t : (2 * n - 2 - t);
    if (mode == BM_ZERO) return 0;
    return (t < 0) ? 0 : (n - 1);
  endfunction

endpackage

// File: rtl/gauss_frame_mem.sv
// Whole-frame pixel store: one synchronous write port, one combinational read.
module gauss_frame_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Pixel write during frame load.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/gauss_stream_filter.sv
// Frame-buffered binomial (Gaussian) filter. A frame is loaded in raster
// order, then each output pixel is built from KSIZE*KSIZE taps, one tap per
// cycle, all channels in parallel.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; once out_valid is raised, out_data/out_last hold steady until
// that transfer.
module gauss_stream_filter
  import gauss_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int KSIZE    = 3,
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [1:0]                   border_mode,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*DATA_W-1:0]   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*DATA_W-1:0]   out_data,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done,
  output state_t                       dbg_state
);

  localparam int NPIX  = ROWS * COLS;
  localparam int AW    = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int RW    = $clog2(ROWS + 1);
  localparam int CW    = $clog2(COLS + 1);
  localparam int KW    = $clog2(KSIZE);
  localparam int HALF  = KSIZE / 2;
  localparam int S     = 2 * (KSIZE - 1);
  localparam int ACC_W = DATA_W + S + 1;
  localparam int PW    = CHANNELS * DATA_W;

  state_t            state_q, state_d;
  logic [1:0]        mode_q;
  logic [AW-1:0]     idx_q;
  logic [RW-1:0]     row_q;
  logic [CW-1:0]     col_q;
  logic [KW-1:0]     tk_q, tl_q;
  logic [ACC_W-1:0]  acc_q [CHANNELS];

  int                ty, tx, my, mx;
  logic              tap_in;
  logic [AW-1:0]     rd_addr;
  logic [PW-1:0]     rd_data;
  logic [KSIZE-1:0]  coef [KSIZE];
  logic [S:0]        weight;
  logic [ACC_W-1:0]  sum [CHANNELS];
  logic [PW-1:0]     result;
  logic              last_tap, last_pix, load_we;

  assign last_tap  = (tk_q == KW'(KSIZE - 1)) && (tl_q == KW'(KSIZE - 1));
  assign last_pix  = (idx_q == AW'(NPIX - 1));
  assign load_we   = (state_q == ST_LOAD) && in_valid;
  assign dbg_state = state_q;

  gauss_frame_mem #(.DEPTH(NPIX), .WIDTH(PW), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (load_we),
    .waddr (idx_q),
    .wdata (in_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Tap coordinate, border folding and frame-memory address of current tap.
  always_comb begin
    ty      = int'(row_q) + int'(tk_q) - HALF;
    tx      = int'(col_q) + int'(tl_q) - HALF;
    tap_in  = (mode_q != BM_ZERO) || (ty >= 0 && ty < ROWS && tx >= 0 && tx < COLS);
    my      = map_coord(ty, ROWS, mode_q);
    mx      = map_coord(tx, COLS, mode_q);
    rd_addr = AW'(my * COLS + mx);
  end

  // Separable binomial weights; the table folds to constants.
  always_comb begin
    for (int i = 0; i < KSIZE; i++) coef[i] = KSIZE'(binom(KSIZE - 1, i));
    weight = (S + 1)'(coef[tk_q]) * (S + 1)'(coef[tl_q]);
  end

  // Per-channel multiply-accumulate and rounded normalisation by 2^S.
  always_comb begin
    result = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      logic [ACC_W-1:0] prod;
      logic [ACC_W-1:0] rnd;
      prod   = tap_in ? (ACC_W'(rd_data[c*DATA_W +: DATA_W]) * ACC_W'(weight)) : '0;
      sum[c] = acc_q[c] + prod;
      rnd    = sum[c] + ACC_W'(2 ** (S - 1));
      result[c*DATA_W +: DATA_W] = rnd[S +: DATA_W];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake/status outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && last_pix) state_d = ST_CONV;
      end
      ST_CONV: begin
        if (last_tap) state_d = ST_EMIT;
      end
      ST_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = last_pix ? ST_DONE : ST_CONV;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counters, accumulators and the held output pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= BM_REPLICATE;
      idx_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      tk_q     <= '0;
      tl_q     <= '0;
      out_data <= '0;
      out_last <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) acc_q[c] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mode_q <= border_mode;
            idx_q  <= '0;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            if (last_pix) begin
              idx_q <= '0;
              row_q <= '0;
              col_q <= '0;
              tk_q  <= '0;
              tl_q  <= '0;
              for (int c = 0; c < CHANNELS; c++) acc_q[c] <= '0;
            end else begin
              idx_q <= idx_q + AW'(1);
            end
          end
        end
        ST_CONV: begin
          if (last_tap) begin
            tk_q     <= '0;
            tl_q     <= '0;
            out_data <= result;
            out_last <= last_pix;
            for (int c = 0; c < CHANNELS; c++) acc_q[c] <= '0;
          end else begin
            for (int c = 0; c < CHANNELS; c++) acc_q[c] <= sum[c];
            if (tl_q == KW'(KSIZE - 1)) begin
              tl_q <= '0;
              tk_q <= tk_q + KW'(1);
            end else begin
              tl_q <= tl_q + KW'(1);
            end
          end
        end
        ST_EMIT: begin
          if (out_ready && !last_pix) begin
            idx_q <= idx_q + AW'(1);
            if (col_q == CW'(COLS - 1)) begin
              col_q <= '0;
              row_q <= row_q + RW'(1);
            end else begin
              col_q <= col_q + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gauss_stream_filter.sv
// Bench for the 4x4, 3x3-kernel, 8-bit, single-channel configuration.
module tb_gauss_stream_filter;
  import gauss_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] border_mode = 2'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;
  logic       done;
  state_t     dbg_state;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q [$];
  logic [7:0] img [16];
  logic [7:0] got [16];
  int         out_count = 0;
  int         neg_cnt = 0;
  int         last_neg = 0;
  int         prev_hs = 0;
  bit         done_flag = 0;
  bit         ready_tied = 0;
  bit         stall_prev = 0;
  logic [8:0] stall_word;
  logic [8:0] exp_word;

  gauss_stream_filter #(.ROWS(4), .COLS(4), .KSIZE(3), .DATA_W(8), .CHANNELS(1)) dut (
    .clk(clk), .rst(rst), .start(start), .border_mode(border_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference model: 3x3 binomial filter on the 4x4 img with border handling.
  function automatic int fold(input int t, input logic [1:0] m, output bit ok);
    ok = 1;
    if (t >= 0 && t < 4) return t;
    if (m == 2'd1) return (t < 0) ? -t : 6 - t;
    if (m == 2'd2) begin ok = 0; return 0; end
    return (t < 0) ? 0 : 3;
  endfunction

  function automatic logic [7:0] golden(input int r, input int c, input logic [1:0] m);
    int w [3] = '{1, 2, 1};
    int acc = 0;
    bit oky, okx;
    int y, x;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        y = fold(r + dr, m, oky);
        x = fold(c + dc, m, okx);
        if (oky && okx) acc += int'(img[y*4 + x]) * w[dr+1] * w[dc+1];
      end
    return 8'((acc + 8) >> 4);
  endfunction

  // Output monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    neg_cnt++;
    if (rst) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_word", 32'({out_last, out_data}), 32'(stall_word));
      end
      stall_prev = out_valid && !out_ready;
      stall_word = {out_last, out_data};
      if (out_valid && out_ready) begin
        chk("out_pending", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          exp_word = exp_q.pop_front();
          chk("out_pixel", 32'({out_last, out_data}), 32'(exp_word));
        end
        if (ready_tied && out_count > 0) chk("pixel_interval", neg_cnt - prev_hs, 10);
        if (out_count < 16) got[out_count] = out_data;
        prev_hs = neg_cnt;
        out_count++;
        if (out_last) last_neg = neg_cnt;
      end
      if (done) begin
        done_flag = 1;
        chk("done_after_last", neg_cnt - last_neg, 1);
      end
    end
  end

  // Drives one frame in; pushes its expected outputs to the scoreboard.
  task automatic load_frame(input logic [1:0] m, input bit rnd_valid);
    int n = 0;
    int g = 0;
    logic rdy;
    out_count = 0;
    done_flag = 0;
    for (int i = 0; i < 16; i++) exp_q.push_back({i == 15, golden(i / 4, i % 4, m)});
    border_mode = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    border_mode = 2'($urandom_range(0, 3));
    chk("in_ready_load", 32'(in_ready), 1);
    while (n < 16 && g < 500) begin
      in_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data = img[n];
      rdy = in_ready;
      @(posedge clk); #1;
      if (in_valid && rdy) n++;
      g++;
    end
    in_valid = 1'b0;
    chk("load_count", n, 16);
    chk("state_after_load", 32'(dbg_state), 32'(ST_CONV));
  endtask

  // Collects the outputs of the running frame until the done pulse.
  task automatic drain(input int stall_at, input bit noise);
    int cyc = 0;
    int stall_left = 5;
    while (!done_flag && cyc < 3000) begin
      out_ready = 1'b1;
      if (stall_at >= 0 && out_count == stall_at && out_valid && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data = 8'($urandom_range(0, 255));
        start = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    chk("done_seen", 32'(done_flag), 1);
    chk("frame_count", out_count, 16);
    chk("queue_empty", exp_q.size(), 0);
    if (stall_at >= 0) chk("stall_applied", stall_left, 0);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk); #1;
  endtask

  initial begin
    int cyc;
    bit saw_valid;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Flat field of 100: output identical, full-rate spacing
    for (int i = 0; i < 16; i++) img[i] = 8'd100;
    ready_tied = 1;
    load_frame(2'd0, 0);
    drain(-1, 0);
    ready_tied = 0;
    for (int i = 0; i < 16; i++) chk("flat_value", 32'(got[i]), 100);

    // Impulse 255 at (1,1), zero border
    for (int i = 0; i < 16; i++) img[i] = 8'd0;
    img[5] = 8'd255;
    load_frame(2'd2, 0);
    drain(-1, 0);
    chk("imp_11", 32'(got[5]), 64);
    chk("imp_01", 32'(got[1]), 32);
    chk("imp_00", 32'(got[0]), 16);
    chk("imp_33", 32'(got[15]), 0);

    // Corner 160, mirror then replicate
    for (int i = 0; i < 16; i++) img[i] = 8'd0;
    img[0] = 8'd160;
    load_frame(2'd1, 0);
    drain(-1, 0);
    chk("corner_mirror", 32'(got[0]), 40);
    load_frame(2'd0, 0);
    drain(-1, 0);
    chk("corner_replicate", 32'(got[0]), 90);

    // Random image, mirror, output stalled on pixel 3
    for (int i = 0; i < 16; i++) img[i] = 8'($urandom_range(0, 255));
    load_frame(2'd1, 0);
    drain(3, 0);

    // Random image, mode 3, ragged in_valid, start/in_valid noise after load
    for (int i = 0; i < 16; i++) img[i] = 8'($urandom_range(0, 255));
    load_frame(2'd3, 1);
    drain(-1, 1);

    // Reset during CONV of pixel 5
    for (int i = 0; i < 16; i++) img[i] = 8'($urandom_range(0, 255));
    load_frame(2'd2, 0);
    out_ready = 1'b1;
    cyc = 0;
    while (!(out_count == 5 && dbg_state == ST_CONV) && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("reached_pixel5", out_count, 5);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 0);
    chk("abort_out_valid", 32'(out_valid), 0);
    chk("abort_out_data", 32'(out_data), 0);
    chk("abort_out_last", 32'(out_last), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    saw_valid = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1;
    end
    chk("abort_no_valid", 32'(saw_valid), 0);
    chk("abort_count", out_count, 5);
    exp_q.delete();
    @(posedge clk); #1;

    // Fresh frame after abort
    for (int i = 0; i < 16; i++) img[i] = 8'($urandom_range(0, 255));
    load_frame(2'd0, 0);
    drain(-1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
